// File: rtl/fu_chk_pkg.sv
// Shared types and constants for the fu self-test vector checker.
package fu_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fu_chk_state_e;

  localparam int DSIZE   = 16;
  localparam int OPSIZE  = 5;
  localparam int MEMSIZE = 64;

  // Response word is {Z, N, C, V, F}: flag bit positions above F.
  localparam int RESP_FLAGS = 4;
  localparam int RESP_Z     = 3;
  localparam int RESP_N     = 2;
  localparam int RESP_C     = 1;
  localparam int RESP_V     = 0;

endpackage

// File: rtl/fu_chk_delay.sv
// Valid-tagged shift register carrying {idx, gold} alongside the fu operands.
module fu_chk_delay #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         pending
);

  logic [D-1:0] vld_p;
  logic [W-1:0] data_p [D];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < D; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= in_data;
    for (int i = 1; i < D; i++) data_p[i] <= data_p[i-1];
  end

  // The last stage is compared this cycle, so only earlier stages count as pending.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < D - 1; i++) pending = pending | vld_p[i];
  end

  assign out_vld  = vld_p[D-1];
  assign out_data = data_p[D-1];

endmodule

// File: rtl/fu_vector_checker.sv
// Self-test sequencer for the fu unit: streams vectors, compares responses to gold.
// Optional macro FU_CHK_STOP_ON_ERR_EN: finish at the first mismatch.
module fu_vector_checker #(
  parameter int DSIZE   = fu_chk_pkg::DSIZE,
  parameter int OPSIZE  = fu_chk_pkg::OPSIZE,
  parameter int MEMSIZE = fu_chk_pkg::MEMSIZE,
  parameter int AW      = $clog2(MEMSIZE),
  parameter int FU_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [AW-1:0]             vec_addr,
  input  logic [OPSIZE+2*DSIZE-1:0] vec_data,
  input  logic [4+DSIZE-1:0]        gold_data,
  output logic [OPSIZE-1:0]         op_o,
  output logic [DSIZE-1:0]          data_a_o,
  output logic [DSIZE-1:0]          data_b_o,
  input  logic [DSIZE-1:0]          F_i,
  input  logic                      Z_i,
  input  logic                      N_i,
  input  logic                      C_i,
  input  logic                      V_i,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [AW:0]               err_cnt,
  output logic [AW-1:0]             first_err_idx
);
  import fu_chk_pkg::*;

  localparam int VW = OPSIZE + 2 * DSIZE;
  localparam int GW = RESP_FLAGS + DSIZE;
  localparam int IW = AW + GW;
  localparam int D  = 1 + FU_LAT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEMSIZE - 1);

  fu_chk_state_e state, state_nxt;
  logic          start_acc;
  logic          rd_vld_p0;
  logic [AW-1:0] rd_idx_p0;
  logic          chk_vld;
  logic [IW-1:0] chk_word;
  logic          dly_pending;
  logic [GW-1:0] resp;
  logic          mism;
  logic          stop_hit;

  assign start_acc = start && (state == ST_IDLE || state == ST_DONE);

`ifdef FU_CHK_STOP_ON_ERR_EN
  assign stop_hit = mism;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_acc) state_nxt = ST_RUN;
      ST_RUN: begin
        if (stop_hit)                  state_nxt = ST_DONE;
        else if (vec_addr == LAST_ADDR) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (stop_hit || (!rd_vld_p0 && !dly_pending)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  assign pass = done && (err_cnt == '0);

  // Address stage: one read per RUN cycle; address saturates at the last vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_addr  <= '0;
      rd_vld_p0 <= 1'b0;
    end else begin
      rd_vld_p0 <= (state == ST_RUN) && !stop_hit;
      if (start_acc)
        vec_addr <= '0;
      else if (state == ST_RUN && vec_addr != LAST_ADDR && !stop_hit)
        vec_addr <= vec_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_p0 <= vec_addr;
  end

  // Issue stage: operands to fu, held between valid reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_o     <= '0;
      data_a_o <= '0;
      data_b_o <= '0;
    end else if (rd_vld_p0) begin
      op_o     <= vec_data[VW-1 -: OPSIZE];
      data_a_o <= vec_data[2*DSIZE-1 -: DSIZE];
      data_b_o <= vec_data[DSIZE-1:0];
    end
  end

  fu_chk_delay #(
    .W(IW),
    .D(D)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .flush    (stop_hit),
    .in_vld   (rd_vld_p0),
    .in_data  ({rd_idx_p0, gold_data}),
    .out_vld  (chk_vld),
    .out_data (chk_word),
    .pending  (dly_pending)
  );

  // Compare stage: exact match of the fu response against the delayed gold word.
  always_comb begin
    resp                   = '0;
    resp[DSIZE-1:0]        = F_i;
    resp[DSIZE + RESP_Z]   = Z_i;
    resp[DSIZE + RESP_N]   = N_i;
    resp[DSIZE + RESP_C]   = C_i;
    resp[DSIZE + RESP_V]   = V_i;
  end

  assign mism = chk_vld && (resp != chk_word[GW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else if (start_acc) begin
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else if (mism) begin
      err_cnt <= err_cnt + 1'b1;
      if (err_cnt == '0) first_err_idx <= chk_word[IW-1:GW];
    end
  end

endmodule

// File: tb/tb_fu_vector_checker.sv
// Scoreboard bench for fu_vector_checker: FU_LAT=1 and FU_LAT=3 instances with a reference fu.
module tb_fu_vector_checker;

  localparam int DS  = 16;
  localparam int OPS = 5;
  localparam int MS  = 64;
  localparam int AWD = 6;
  localparam int VW  = OPS + 2 * DS;
  localparam int GW  = 4 + DS;
`ifdef FU_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct {
    int start_cyc;
    int lat;
    int err;
    int first;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  logic rst, start_a, start_b;
  logic [VW-1:0] vec_mem [MS];
  logic [GW-1:0] gold_a [MS];
  logic [GW-1:0] gold_b [MS];

  logic [AWD-1:0] addr_a, addr_b, first_a, first_b;
  logic [VW-1:0]  vdata_a, vdata_b;
  logic [GW-1:0]  gdata_a, gdata_b, rb1, rb2;
  logic [OPS-1:0] op_a, op_b;
  logic [DS-1:0]  da_a, db_a, da_b, db_b, F_a, F_b;
  logic Z_a, N_a, C_a, V_a, Z_b, N_b, C_b, V_b;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [AWD:0]   err_a, err_b;

  function automatic logic [GW-1:0] fu_ref(logic [OPS-1:0] op, logic [DS-1:0] a, logic [DS-1:0] b);
    logic [DS:0]   w;
    logic [DS-1:0] f;
    logic c, v;
    w = '0; c = 1'b0; v = 1'b0;
    case (op)
      5'd0: begin
        w = {1'b0, a} + {1'b0, b}; f = w[DS-1:0]; c = w[DS];
        v = (a[DS-1] == b[DS-1]) && (f[DS-1] != a[DS-1]);
      end
      5'd1: begin
        w = {1'b0, a} - {1'b0, b}; f = w[DS-1:0]; c = w[DS];
        v = (a[DS-1] != b[DS-1]) && (f[DS-1] != a[DS-1]);
      end
      5'd2:    f = a & b;
      5'd3:    f = a | b;
      5'd4:    f = a ^ b;
      default: f = a;
    endcase
    return {(f == '0), f[DS-1], c, v, f};
  endfunction

  // Memories with one-cycle read latency and reference fu models.
  always @(posedge clk) begin
    vdata_a <= vec_mem[addr_a];
    gdata_a <= gold_a[addr_a];
    {Z_a, N_a, C_a, V_a, F_a} <= fu_ref(op_a, da_a, db_a);
    vdata_b <= vec_mem[addr_b];
    gdata_b <= gold_b[addr_b];
    rb1 <= fu_ref(op_b, da_b, db_b);
    rb2 <= rb1;
    {Z_b, N_b, C_b, V_b, F_b} <= rb2;
  end

  fu_vector_checker #(.DSIZE(DS), .OPSIZE(OPS), .MEMSIZE(MS), .AW(AWD), .FU_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_addr(addr_a), .vec_data(vdata_a),
    .gold_data(gdata_a), .op_o(op_a), .data_a_o(da_a), .data_b_o(db_a), .F_i(F_a),
    .Z_i(Z_a), .N_i(N_a), .C_i(C_a), .V_i(V_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .first_err_idx(first_a));

  fu_vector_checker #(.DSIZE(DS), .OPSIZE(OPS), .MEMSIZE(MS), .AW(AWD), .FU_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_addr(addr_b), .vec_data(vdata_b),
    .gold_data(gdata_b), .op_o(op_b), .data_a_o(da_b), .data_b_o(db_b), .F_i(F_b),
    .Z_i(Z_b), .N_i(N_b), .C_i(C_b), .V_i(V_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .first_err_idx(first_b));

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitors: on each rising done, pop the expected result and compare.
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (done_a && !done_a_q) begin
      if (q_a.size() == 0) check("A unexpected done", 1, 0);
      else begin
        e = q_a.pop_front();
        check("A latency", cyc - e.start_cyc, e.lat);
        check("A err_cnt", int'(err_a), e.err);
        check("A first_err_idx", int'(first_a), e.first);
        check("A pass", int'(pass_a), e.pass);
        check("A busy at done", int'(busy_a), 0);
      end
    end
    done_a_q = done_a;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (done_b && !done_b_q) begin
      if (q_b.size() == 0) check("B unexpected done", 1, 0);
      else begin
        e = q_b.pop_front();
        check("B latency", cyc - e.start_cyc, e.lat);
        check("B err_cnt", int'(err_b), e.err);
        check("B first_err_idx", int'(first_b), e.first);
        check("B pass", int'(pass_b), e.pass);
      end
    end
    done_b_q = done_b;
  end

  task automatic init_mem();
    logic [OPS-1:0] op;
    logic [DS-1:0]  a, b;
    for (int i = 0; i < MS; i++) begin
      op = OPS'(i % 6);
      a  = DS'(i * 4099 + 16'h7ff0);
      b  = DS'(i * 331) ^ 16'h5a5a;
      if (i == 0) begin a = '0; b = '0; end
      vec_mem[i] = {op, a, b};
      gold_a[i]  = fu_ref(op, a, b);
      gold_b[i]  = gold_a[i];
    end
  endtask

  // Pulse start on A; optionally poke start at run cycles 10 and 30, or reset at 20.
  task automatic run_a(int lat, int err, int first, int pass, bit pokes, bit abort);
    exp_t e;
    int s, k;
    @(negedge clk);
    start_a = 1'b1;
    s = cyc;
    if (!abort) begin
      e.start_cyc = s; e.lat = lat; e.err = err; e.first = first; e.pass = pass;
      q_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
    check("A busy after start", int'(busy_a), 1);
    k = 0;
    while (!done_a && k < 200) begin
      if (abort && cyc - s == 20) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst vec_addr", int'(addr_a), 0);
        check("rst op_o", int'(op_a), 0);
        check("rst data_a_o", int'(da_a), 0);
        check("rst data_b_o", int'(db_a), 0);
        check("rst busy", int'(busy_a), 0);
        check("rst err_cnt", int'(err_a), 0);
        check("rst first_err_idx", int'(first_a), 0);
        repeat (6) @(negedge clk);
        check("rst stays idle", int'({busy_a, done_a, pass_a}), 0);
        return;
      end
      start_a = pokes && (cyc - s == 10 || cyc - s == 30);
      @(negedge clk);
      k++;
    end
    start_a = 1'b0;
    if (k >= 200) check("A done timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_b(int lat, int err, int first, int pass);
    exp_t e;
    int k;
    @(negedge clk);
    start_b = 1'b1;
    e.start_cyc = cyc; e.lat = lat; e.err = err; e.first = first; e.pass = pass;
    q_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (!done_b && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("B done timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    init_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset vec_addr", int'(addr_a), 0);
    check("reset operands", int'({op_a, da_a, db_a}), 0);
    check("reset busy/done/pass", int'({busy_a, done_a, pass_a}), 0);
    check("reset err_cnt", int'(err_a), 0);
    check("reset first_err_idx", int'(first_a), 0);

    run_a(68, 0, 0, 1, 1'b0, 1'b0);

    gold_a[5][DS+3]  = ~gold_a[5][DS+3];
    gold_a[40][DS+3] = ~gold_a[40][DS+3];
    if (STOP) run_a(10, 1, 5, 0, 1'b0, 1'b0);
    else      run_a(68, 2, 5, 0, 1'b0, 1'b0);
    gold_a[5]  = gold_b[5];
    gold_a[40] = gold_b[40];

    run_a(68, 0, 0, 1, 1'b1, 1'b0);

    run_a(0, 0, 0, 0, 1'b0, 1'b1);
    run_a(68, 0, 0, 1, 1'b0, 1'b0);

    run_b(70, 0, 0, 1);
    gold_b[63][0] = ~gold_b[63][0];
    run_b(70, 1, 63, 0);

    gold_a[7][DS+1] = ~gold_a[7][DS+1];
    gold_a[9][2]    = ~gold_a[9][2];
    if (STOP) run_a(12, 1, 7, 0, 1'b0, 1'b0);
    else      run_a(68, 2, 7, 0, 1'b0, 1'b0);

    check("A results pending", q_a.size(), 0);
    check("B results pending", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
